// File: rtl/i4001_timing_pkg.sv
// rtl/i4001_timing_pkg.sv - shared i4001/i4004 machine-state and sub-phase encodings
package i4001_timing_pkg;

  localparam int NUM_STATES = 8;
  localparam int SUB_W      = 2;

  typedef enum logic [2:0] {
    ST_A1 = 3'd0,
    ST_A2 = 3'd1,
    ST_A3 = 3'd2,
    ST_M1 = 3'd3,
    ST_M2 = 3'd4,
    ST_X1 = 3'd5,
    ST_X2 = 3'd6,
    ST_X3 = 3'd7
  } state_e;

  localparam logic [SUB_W-1:0] SUB_PHI1 = 2'd0;
  localparam logic [SUB_W-1:0] SUB_GAP1 = 2'd1;
  localparam logic [SUB_W-1:0] SUB_PHI2 = 2'd2;
  localparam logic [SUB_W-1:0] SUB_GAP2 = 2'd3;

endpackage

// File: rtl/cycle_timing_gen_rise_detect.sv
// rtl/cycle_timing_gen_rise_detect.sv - single-cycle rising-edge detector with configurable reset history
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic q_q;

  // Keep the previous sample; a reset value of 1 stops a level already high at release from counting
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_q <= RESET_VAL;
    else         q_q <= d_i;
  end

  assign rise_o = d_i & ~q_q;

endmodule

// File: rtl/cycle_timing_gen.sv
// rtl/cycle_timing_gen.sv - 8-state instruction-cycle timing from TICK_IN rises; CYCLE_TIMING_GEN_STEP_EN adds single-step
module cycle_timing_gen import i4001_timing_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  output logic       phi1_o,
  output logic       phi2_o,
  output logic       sync_o,
  output logic [2:0] state_o,
  output logic       cyc_start_o
`ifdef CYCLE_TIMING_GEN_STEP_EN
  ,
  input  logic       step_mode_i,
  input  logic       step_req_i
`endif
);

  logic             tick;
  logic             at_end;
  logic             stall;
  logic             advance;
  logic [SUB_W-1:0] sub_q, sub_d;
  state_e           state_q, state_d;
  logic             phi1_q, phi2_q, sync_q, cyc_start_q;

  rise_detect #(.RESET_VAL(1'b1)) u_tick_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (tick_i),
    .rise_o (tick)
  );

  assign at_end = (state_q == ST_X3) && (sub_q == SUB_GAP2);

`ifdef CYCLE_TIMING_GEN_STEP_EN
  logic req_rise;
  logic token_q, token_d;
  logic consume;

  rise_detect #(.RESET_VAL(1'b1)) u_req_rise (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (step_req_i),
    .rise_o (req_rise)
  );

  // In step mode the cycle boundary is gated by a pending request token
  assign stall   = step_mode_i & at_end & ~token_q;
  assign consume = tick & step_mode_i & at_end & token_q;

  // A new request on the consuming edge re-arms the token for the next cycle
  always_comb begin
    token_d = token_q;
    if (consume)  token_d = 1'b0;
    if (req_rise) token_d = 1'b1;
  end

  // Token register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) token_q <= 1'b0;
    else         token_q <= token_d;
  end
`else
  assign stall = 1'b0;
`endif

  assign advance = tick & ~stall;

  // Next sub-phase / state; the state moves on when the last sub-phase is left
  always_comb begin
    sub_d   = sub_q + 2'd1;
    state_d = state_q;
    if (sub_q == SUB_GAP2) state_d = state_e'(state_q + 3'd1);
  end

  // Step the counters and register the decoded levels from the next-state values
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q       <= SUB_GAP2;
      state_q     <= ST_X3;
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      sync_q      <= 1'b0;
      cyc_start_q <= 1'b0;
    end else begin
      cyc_start_q <= 1'b0;
      if (advance) begin
        sub_q       <= sub_d;
        state_q     <= state_d;
        phi1_q      <= (sub_d == SUB_PHI1);
        phi2_q      <= (sub_d == SUB_PHI2);
        sync_q      <= (state_d == ST_X3);
        cyc_start_q <= (state_d == ST_A1) && (sub_d == SUB_PHI1);
      end
    end
  end

  assign phi1_o      = phi1_q;
  assign phi2_o      = phi2_q;
  assign sync_o      = sync_q;
  assign state_o     = state_q;
  assign cyc_start_o = cyc_start_q;

endmodule

// File: tb/tb_cycle_timing_gen.sv
// tb/tb_cycle_timing_gen.sv - self-checking bench for cycle_timing_gen
module tb_cycle_timing_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       step_mode;
  logic       step_req;
  logic       phi1, phi2, sync, cyc_start;
  logic [2:0] state;

  always #5 clk = ~clk;

  cycle_timing_gen dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .tick_i      (tick),
    .phi1_o      (phi1),
    .phi2_o      (phi2),
    .sync_o      (sync),
    .state_o     (state),
    .cyc_start_o (cyc_start)
`ifdef CYCLE_TIMING_GEN_STEP_EN
    ,
    .step_mode_i (step_mode),
    .step_req_i  (step_req)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: n = number of steps taken since reset
  int n;
  bit m_prev_t, m_prev_r, m_tok, m_cs;

  typedef struct {
    bit         t;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [6:0] dut_out();
    return {state, phi1, phi2, sync, cyc_start};
  endfunction

  function automatic logic [6:0] model_out();
    int p, st, sb;
    if (n == 0) return 7'b111_0000;
    p  = (n - 1) % 32;
    st = p / 4;
    sb = p % 4;
    return {3'(st), sb == 0, sb == 2, st == 7, m_cs};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    check(name, 32'(dut_out()), 32'(model_out()));
    check({name, "_overlap"}, 32'(phi1 & phi2), 32'd0);
  endtask

  task automatic model_reset();
    n = 0; m_prev_t = 1'b1; m_prev_r = 1'b1; m_tok = 1'b0; m_cs = 1'b0;
  endtask

  task automatic model_clk();
    bit rise, rr, at_end;
    rise = tick && !m_prev_t;
    m_prev_t = tick;
    rr = step_req && !m_prev_r;
    m_prev_r = step_req;
    at_end = (n == 0) || (((n - 1) % 32) == 31);
    m_cs = 1'b0;
    if (rise && !(step_mode && at_end && !m_tok)) begin
      if (step_mode && at_end) m_tok = 1'b0;
      n++;
      if (((n - 1) % 32) == 0) m_cs = 1'b1;
    end
    if (rr) m_tok = 1'b1;
  endtask

  // Drive inputs, take one clock edge, advance the model, sample 1 time unit later
  task automatic step(input bit t, input bit m, input bit r);
    tick = t;
`ifdef CYCLE_TIMING_GEN_STEP_EN
    step_mode = m;
    step_req  = r;
`else
    step_mode = 1'b0;
    step_req  = 1'b0;
`endif
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic do_reset(input bit t0);
    rst_n = 1'b0; tick = t0; step_mode = 1'b0; step_req = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check("reset_state", 32'(dut_out()), 32'b111_0000);
    rst_n = 1'b1;
  endtask

  task automatic run_ticks(input int cnt, input bit m, input bit r, input string name);
    for (int i = 0; i < cnt; i++) begin
      step(1'b1, m, r); check_model(name);
      step(1'b0, m, r); check_model(name);
    end
  endtask

  initial begin
    int cs_cnt, phi1_cnt;
    bit t, m, r;

    // {tick, {state, phi1, phi2, sync, cyc_start}} with TICK_IN high across reset release
    tbl[0]  = '{1'b1, 7'b111_0000};
    tbl[1]  = '{1'b1, 7'b111_0000};
    tbl[2]  = '{1'b0, 7'b111_0000};
    tbl[3]  = '{1'b1, 7'b000_1001};
    tbl[4]  = '{1'b1, 7'b000_1000};
    tbl[5]  = '{1'b0, 7'b000_1000};
    tbl[6]  = '{1'b1, 7'b000_0000};
    tbl[7]  = '{1'b0, 7'b000_0000};
    tbl[8]  = '{1'b1, 7'b000_0100};
    tbl[9]  = '{1'b0, 7'b000_0100};
    tbl[10] = '{1'b1, 7'b000_0000};
    tbl[11] = '{1'b1, 7'b000_0000};
    tbl[12] = '{1'b0, 7'b000_0000};
    tbl[13] = '{1'b1, 7'b001_1000};

    #2;
    do_reset(1'b1);
    foreach (tbl[i]) begin
      step(tbl[i].t, 1'b0, 1'b0);
      check($sformatf("table_%0d", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // TICK_IN held high for 100 CLK is a single step
    step(1'b0, 1'b0, 1'b0); check_model("hold_pre");
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 1'b0, 1'b0); check_model("hold_high");
    end
    check("hold_one_step", 32'(dut_out()), 32'b001_0000);

    // Asynchronous reset in M2
    do_reset(1'b0);
    while (n < 17) begin
      step(1'b1, 1'b0, 1'b0); check_model("to_m2");
      step(1'b0, 1'b0, 1'b0); check_model("to_m2");
    end
    check("in_m2", 32'(state), 32'd4);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(dut_out()), 32'b111_0000);
    tick = 1'b0;
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0); check_model("post_reset_idle");
    step(1'b1, 1'b0, 1'b0);
    check("restart_a1", 32'(dut_out()), 32'b000_1001);

    // Tick every 2 CLK, 64 rises: two full cycles
    do_reset(1'b0);
    cs_cnt = 0; phi1_cnt = 0;
    for (int i = 0; i < 128; i++) begin
      step(i[0], 1'b0, 1'b0); check_model("fast");
      cs_cnt   += int'(cyc_start);
      phi1_cnt += int'(phi1);
    end
    check("fast_cs_count", 32'(cs_cnt), 32'd2);
    check("fast_phi1_count", 32'(phi1_cnt), 32'd32);
    check("fast_end_x3", 32'(dut_out()), 32'b111_0010);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check("fast_tick65", 32'(dut_out()), 32'b000_1001);

`ifdef CYCLE_TIMING_GEN_STEP_EN
    // Single-step: one request buys one cycle, then stall at X3 sub3
    do_reset(1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    run_ticks(32, 1'b1, 1'b1, "step_cycle1");
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b1);
      check("stall_hi", 32'(dut_out()), 32'b111_0010);
      step(1'b0, 1'b1, 1'b1);
      check("stall_lo", 32'(dut_out()), 32'b111_0010);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("step_enter_a1", 32'(dut_out()), 32'b000_1001);
    step(1'b0, 1'b1, 1'b1);
    run_ticks(31, 1'b1, 1'b1, "step_cycle2");
    step(1'b1, 1'b1, 1'b1);
    check("step_stall_again", 32'(dut_out()), 32'b111_0010);
    // Request rises on the consuming edge: token survives for one more cycle
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    check("consume_and_set", 32'(dut_out()), 32'b000_1001);
    step(1'b0, 1'b1, 1'b1);
    run_ticks(31, 1'b1, 1'b1, "reset_token_cycle");
    step(1'b1, 1'b1, 1'b1);
    check("token_kept", 32'(dut_out()), 32'b000_1001);
`endif

    // Randomised run against the model
    do_reset(1'b0);
    m = 1'b0; r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) m = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) r = ~r;
      t = 1'($urandom_range(0, 1));
      step(t, m, r);
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
